// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a 2^ADDR_W x DATA_W register file.
// Define SPI_SLAVE_AUTOINC_EN for multi-word bursts with address increment.
module spi_slave_regs #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [DATA_W-1:0] loc_dat_o,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [2:0]        sck_q;
  logic [2:0]        cs_q;
  logic [1:0]        mosi_q;
  logic              sck_rise;
  logic              sck_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic              mosi_s;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        cmd_sr;
  logic [7:0]        cmd_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cmd_addr;
  logic              is_wr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic              last_bit;
  logic              commit;

  logic [DATA_W-1:0] regs [DEPTH];

  // cs resets high so no phantom frame start follows reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_s   = mosi_q[1];

  assign cmd_next = {cmd_sr[6:0], mosi_s};
  assign cmd_addr = cmd_next[ADDR_W-1:0];
  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_s};
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign commit   = !cs_rise && (state == ST_DATA) && sck_rise
                    && is_wr && last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      addr     <= '0;
      is_wr    <= 1'b0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      spi_miso <= 1'b0;
    end else if (cs_rise) begin
      state    <= ST_IDLE;
      spi_miso <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            cmd_sr  <= cmd_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              addr    <= cmd_addr;
              is_wr   <= cmd_next[7];
              tx_sr   <= regs[cmd_addr];
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            rx_sr   <= rx_next;
            if (last_bit) begin
`ifdef SPI_SLAVE_AUTOINC_EN
              addr <= addr + ADDR_W'(1);
              if (!is_wr) tx_sr <= regs[addr + ADDR_W'(1)];
`else
              state    <= ST_DONE;
              spi_miso <= 1'b0;
`endif
            end
          end else if (sck_fall && !is_wr) begin
            spi_miso <= tx_sr[DATA_W-1];
            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
        ST_DONE: spi_miso <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= commit;
      if (commit) begin
        regs[addr] <= rx_next;
        wr_addr    <= addr;
        wr_data    <= rx_next;
      end
    end
  end

  // same-cycle SPI write returns the old word here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_dat_o <= '0;
      busy      <= 1'b0;
    end else begin
      loc_dat_o <= regs[loc_addr];
      busy      <= ~cs_q[1];
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs against an array model.
// SPI_SLAVE_AUTOINC_EN selects the burst test instead of the extra-clock test.
module tb_spi_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [3:0]  loc_addr = '0;
  logic [31:0] loc_dat_o;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [31:0] model [16];
  logic [3:0]  obs_a [$];
  logic [31:0] obs_d [$];

  spi_slave_regs #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .loc_addr(loc_addr), .loc_dat_o(loc_dat_o),
    .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && wr_stb) begin
      obs_a.push_back(wr_addr);
      obs_d.push_back(wr_data);
    end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bit_cyc(input logic m, output logic s);
    spi_mosi = m;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    s = spi_miso;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic frame(input logic [127:0] tx, input int n,
                       output logic [127:0] rx);
    logic b;
    rx = '0;
    obs_a.delete();
    obs_d.delete();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bit_cyc(tx[127-i], b);
      rx[127-i] = b;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    logic [127:0] tx, rx;
    tx = '0;
    tx[127:120] = {1'b1, 3'($urandom), a};
    tx[119:88] = d;
    frame(tx, 40, rx);
    model[a] = d;
    check("wr_cnt", 32'(obs_a.size()), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'(a));
    check("wr_data", wr_data, d);
    check("wr_miso", 32'(|rx), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a);
    logic [127:0] tx, rx;
    tx = '0;
    tx[127:120] = {1'b0, 3'($urandom), a};
    frame(tx, 40, rx);
    check("rd_data", rx[119:88], model[a]);
    check("rd_cmd_miso", 32'(rx[127:120]), 32'd0);
    check("rd_no_wr", 32'(obs_a.size()), 32'd0);
  endtask

  task automatic loc_chk(input logic [3:0] a);
    loc_addr = a;
    repeat (2) @(negedge clk);
    check("loc", loc_dat_o, model[a]);
  endtask

  logic [127:0] tx, rx;
  logic         b;

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_stb", 32'(wr_stb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_waddr", 32'(wr_addr), 0);
    check("rst_wdata", wr_data, 0);
    check("rst_loc", loc_dat_o, 0);

    // directed write then read
    do_write(4'd3, 32'hDEADBEEF);
    do_read(4'd3);
    loc_chk(4'd3);

    // busy tracks chip select
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_hi", 32'(busy), 1);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_lo", 32'(busy), 0);

    for (int k = 0; k < 24; k++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a);
    end
    for (int i = 0; i < 16; i++) loc_chk(4'(i));

    // aborted write after 20 data bits
    tx = '0;
    tx[127:120] = 8'h87;
    tx[119:88] = ~model[7];
    frame(tx, 28, rx);
    check("abort_cnt", 32'(obs_a.size()), 0);
    loc_chk(4'd7);
    do_read(4'd7);

`ifdef SPI_SLAVE_AUTOINC_EN
    tx = '0;
    tx[127:120] = 8'h8F;
    tx[119:88] = 32'h11111111;
    tx[87:56] = 32'h22222222;
    frame(tx, 72, rx);
    model[15] = 32'h11111111;
    model[0] = 32'h22222222;
    check("ai_cnt", 32'(obs_a.size()), 2);
    if (obs_a.size() == 2) begin
      check("ai_a0", 32'(obs_a[0]), 15);
      check("ai_a1", 32'(obs_a[1]), 0);
      check("ai_d0", obs_d[0], 32'h11111111);
      check("ai_d1", obs_d[1], 32'h22222222);
    end
    tx = '0;
    tx[127:120] = 8'h0F;
    frame(tx, 72, rx);
    check("ai_rd0", rx[119:88], model[15]);
    check("ai_rd1", rx[87:56], model[0]);
`else
    tx = '0;
    tx[127:120] = 8'h82;
    tx[119:88] = $urandom;
    tx[87:56] = $urandom;
    frame(tx, 72, rx);
    model[2] = tx[119:88];
    check("xtra_cnt", 32'(obs_a.size()), 1);
    check("xtra_data", wr_data, model[2]);
    check("xtra_miso", 32'(|rx[87:0]), 0);
    do_read(4'd2);
`endif

    // read snapshot, first bit ready at the 9th rise
    do_write(4'd4, 32'hA5A5A5A5);
    tx = '0;
    tx[127:120] = 8'h04;
    frame(tx, 40, rx);
    check("snap_first", 32'(rx[119]), 1);
    check("snap_word", rx[119:88], 32'hA5A5A5A5);

    // reset in the middle of a write
    do_write(4'd5, $urandom | 32'h1);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) bit_cyc(1'b1, b);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check("mrst_miso", 32'(spi_miso), 0);
    check("mrst_stb", 32'(wr_stb), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_waddr", 32'(wr_addr), 0);
    check("mrst_wdata", wr_data, 0);
    check("mrst_loc", loc_dat_o, 0);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(4'd5);
    loc_chk(4'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 responder: the far end of the SPI link driven by the `SPI_MASTER`. It decodes an 8-bit command byte followed by 32-bit data words, and holds a 16 × 32-bit register file. SPI writes update the register file; SPI reads return register contents on MISO. All SPI pins are oversampled in the single system clock domain. A local read port and a write-notify strobe expose the register file to surrounding logic. The block serves as the on-board peripheral and as the bench counterpart for the master.

## Interface
- `ADDR_W`, 4: register address width; the register file has 2^ADDR_W words.
- `DATA_W`, 32: register and SPI data word width.

- `clk`  in  1  system clock; must run at ≥ 8× the SPI clock frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_clk`  in  1  SPI serial clock, idle low (mode 0).
- `spi_cs_n`  in  1  chip select, active low.
- `spi_mosi`  in  1  serial data from master.
- `spi_miso`  out  1  serial data to master; always driven, never tri-stated.
- `loc_addr`  in  ADDR_W  local read address.
- `loc_dat_o`  out  DATA_W  registered local read data.
- `wr_stb`  out  1  one-cycle pulse when an SPI write commits.
- `wr_addr`  out  ADDR_W  address of the committed write; held until the next commit.
- `wr_data`  out  DATA_W  data of the committed write; held until the next commit.
- `busy`  out  1  high while the synchronized chip select is asserted.

## Operation
- **Synchronization:** `spi_clk`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchronizer. Edges are detected on the second stage against a third register.
- **Command byte:** 8 bits, MSB first.
  - Bit 7 is 1 for write, 0 for read.
  - Bits 6:4 are reserved and ignored.
  - Bits 3:0 are the register address.
- **Sampling and shifting:** MOSI is sampled on SCK rise events. MISO changes on SCK fall events.
- **FSM states:** IDLE, CMD, DATA, DONE.
  - IDLE → CMD on the CS fall event. The bit counter clears.
  - CMD: shift in 8 bits. On the 8th rise, latch the address and direction, then go to DATA.
    - For a read, the 8th rise also loads `tx_sr` with `reg[addr]` (snapshot).
  - DATA: count 32 bits.
    - Write: shift MOSI into `rx_sr`. On the 32nd rise, write `reg[addr]`, pulse `wr_stb`, and update `wr_addr`/`wr_data`.
    - Read: on each fall event, drive `tx_sr[31]` onto MISO, then shift left.
    - After the 32nd bit, go to DONE (see Configuration for the alternative).
  - DONE: ignore SCK and hold MISO at 0 until CS rises.
  - From any state, the CS rise event returns the FSM to IDLE and drives MISO to 0. A partially received write word is discarded.
- **MISO outside a read:** 0 in IDLE and CMD, and in DATA during a write.
- **Local port:** `loc_dat_o <= reg[loc_addr]` every cycle. If the SPI write and the local read hit the same address in the same cycle, `loc_dat_o` returns the old value.
- **Reset values:** all registers 0; `spi_miso`, `wr_stb`, `busy` = 0; `wr_addr`, `wr_data`, `loc_dat_o` = 0; FSM in IDLE.

## Timing
- Event latency: a pin edge is detected 2–3 `clk` cycles after it occurs.
- MISO update: MISO changes 1 cycle after the detected fall event, which is at most 4 cycles after the pin edge. At ≥ 8× oversampling this meets the master's sampling on the next rise.
- First read bit: driven after the first SCK fall that follows the 8th command rise.
- Write commit: `wr_stb` is high for exactly 1 cycle, registered 1 cycle after the 32nd data rise event. The register file is updated in that same cycle.
- `busy` follows synchronized CS with 2 cycles of latency.
- A CS rise event and an SCK rise event in the same cycle: the CS rise takes priority and the bit is not consumed.
- Reset asserted mid-transfer clears everything immediately. The next transfer requires a fresh CS fall.

## Configuration
- `SPI_SLAVE_AUTOINC_EN` defined: after each 32-bit word, the address increments modulo 2^ADDR_W and the FSM stays in DATA.
  - Writes commit one word at a time, each with its own `wr_stb`.
  - Reads reload `tx_sr` from the new address on the 32nd rise.
- `SPI_SLAVE_AUTOINC_EN` undefined: a single word per transfer; the FSM goes to DONE.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-transfer → all outputs 0; a subsequent read of address 5 returns 0x00000000.
- **Write then read:** write 0x80|0x3 followed by 0xDEADBEEF, with SCK at `clk`/8 → one `wr_stb`, `wr_addr` = 3, `wr_data` = 0xDEADBEEF. Then read 0x03 → MISO returns 0xDEADBEEF, and `loc_addr` = 3 yields 0xDEADBEEF.
- **Aborted write:** raise CS after 20 data bits of a write to address 7 → no `wr_stb`; `reg[7]` unchanged; the FSM is back in IDLE.
- **Extra clocks without autoincrement:** 72 SCK pulses on a write to address 2 (macro undefined) → exactly one commit; MISO stays 0 after bit 40.
- **Autoincrement wrap:** with `SPI_SLAVE_AUTOINC_EN` defined, write to address 15 with two words 0x11111111 and 0x22222222 → two `wr_stb` pulses at addresses 15 then 0. A burst read from 15 returns both words in order.
- **Read snapshot:** during an SPI read of address 4, a write to 4 in the same CS frame is impossible. Instead, preload `reg[4]` = 0xA5A5A5A5, read it, and check MISO reproduces it bit-exactly MSB first, with the first bit present before the 9th SCK rise.
